// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS BCD stopwatch/timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  // BCD compare of minutes is a plain binary compare once both digits are legal.
  function automatic logic preset_valid(input logic [7:0] pmin,
                                        input logic [7:0] psec,
                                        input logic [7:0] min_limit);
    return (pmin[7:4] <= DIGIT_MAX) && (pmin[3:0] <= DIGIT_MAX) &&
           (psec[7:4] <= SEC_TENS_MAX) && (psec[3:0] <= DIGIT_MAX) &&
           (pmin <= min_limit);
  endfunction

endpackage

// File: rtl/stopwatch_counter_digit.sv
// One BCD digit with runtime modulus, up/down count and parallel load.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic dir,
  input  logic load,
  input  bcd_t load_val,
  input  bcd_t max_val,
  output bcd_t value,
  output logic carry
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      if (!dir) begin
        value_d = (value_q == max_val) ? 4'd0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == 4'd0) ? max_val : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  // Carry on wrap up, borrow on wrap down; gated by en so digits chain directly.
  assign carry = en && (dir ? (value_q == 4'd0) : (value_q == max_val));
  assign value = value_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch/timer driven by divider ticks.
// Optional lap-hold display freeze enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MIN_LIMIT             = 8'h99,
  parameter bit         START_DOWN_EMPTY_DONE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic       mode,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       lap,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic        load_err_q, load_err_d;
  logic        cnt_load, cnt_en;
  logic [15:0] cnt_load_val;
  logic [15:0] count;
  bcd_t        sec_ones, sec_tens, min_ones, min_tens;
  logic        c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

  assign count = {min_tens, min_ones, sec_tens, sec_ones};

  bcd_digit_counter u_sec_ones (
    .clk(clk), .reset(reset), .en(cnt_en), .dir(mode_q), .load(cnt_load),
    .load_val(cnt_load_val[3:0]), .max_val(DIGIT_MAX),
    .value(sec_ones), .carry(c_sec_ones));

  bcd_digit_counter u_sec_tens (
    .clk(clk), .reset(reset), .en(c_sec_ones), .dir(mode_q), .load(cnt_load),
    .load_val(cnt_load_val[7:4]), .max_val(SEC_TENS_MAX),
    .value(sec_tens), .carry(c_sec_tens));

  bcd_digit_counter u_min_ones (
    .clk(clk), .reset(reset), .en(c_sec_tens), .dir(mode_q), .load(cnt_load),
    .load_val(cnt_load_val[11:8]), .max_val(DIGIT_MAX),
    .value(min_ones), .carry(c_min_ones));

  bcd_digit_counter u_min_tens (
    .clk(clk), .reset(reset), .en(c_min_ones), .dir(mode_q), .load(cnt_load),
    .load_val(cnt_load_val[15:12]), .max_val(DIGIT_MAX),
    .value(min_tens), .carry(c_min_tens));

  // Terminal values stop the chain before it would wrap, so the top carry is never used.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    load_err_d   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else if (load && state_q != ST_RUN) begin
      if (preset_valid(preset_min, preset_sec, MIN_LIMIT)) begin
        cnt_load     = 1'b1;
        cnt_load_val = {preset_min, preset_sec};
        state_d      = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      if (start_stop) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: begin
            if (mode && count == 16'h0000) begin
              if (START_DOWN_EMPTY_DONE) begin
                state_d = ST_DONE;
                mode_d  = mode;
              end
            end else begin
              state_d = ST_RUN;
              mode_d  = mode;
            end
          end
          ST_RUN:  state_d = ST_PAUSE;
          default: state_d = state_q;
        endcase
      end
      if (tick && state_q == ST_RUN) begin
        if (!mode_q) begin
          if (count == {MIN_LIMIT, 8'h59}) state_d = ST_DONE;
          else                             cnt_en  = 1'b1;
        end else if (count == 16'h0000) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (count == 16'h0001) state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] held_q, held_d;

  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (cnt_load || state_d == ST_DONE) begin
      hold_d = 1'b0;
    end else if (lap && !load_err_d && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      hold_d = !hold_q;
      if (!hold_q) held_d = count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end

  assign {disp_min, disp_sec} = hold_q ? held_q : count;
`else
  logic lap_unused;
  assign lap_unused           = lap;
  assign {disp_min, disp_sec} = count;
`endif

  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign load_err = load_err_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: total-seconds reference model plus directed literal checks.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset, tick, start_stop, clear, load, mode, lap;
  logic [7:0] preset_min, preset_sec;
  logic [7:0] disp_min, disp_sec;
  logic       running, done, load_err;

  int checks   = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int LIMIT_TOT = 99 * 60 + 59;

  int m_tot, m_held, m_st, nst;
  bit m_mode, m_err, m_hold, m_valid;

  always #5 clk = ~clk;

  stopwatch_counter dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
    .clear(clear), .load(load), .mode(mode), .preset_min(preset_min),
    .preset_sec(preset_sec), .lap(lap), .disp_min(disp_min),
    .disp_sec(disp_sec), .running(running), .done(done), .load_err(load_err));

  function automatic int bcd_to_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  // Reference model: time kept as a plain total-seconds integer.
  always @(posedge clk) begin
    if (reset) begin
      m_st = M_IDLE; m_tot = 0; m_mode = 0; m_err = 0; m_hold = 0; m_held = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_err = 0;
      nst   = m_st;
      if (clear) begin
        nst = M_IDLE; m_tot = 0; m_hold = 0;
      end else if (load && m_st != M_RUN) begin
        if (preset_min[7:4] < 10 && preset_min[3:0] < 10 &&
            preset_sec[7:4] < 6 && preset_sec[3:0] < 10 &&
            bcd_to_int(preset_min) <= 99) begin
          m_tot = bcd_to_int(preset_min) * 60 + bcd_to_int(preset_sec);
          nst = M_IDLE; m_hold = 0;
        end else begin
          m_err = 1;
        end
      end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
        if (lap && (m_st == M_RUN || m_st == M_PAUSE)) begin
          if (!m_hold) m_held = m_tot;
          m_hold = !m_hold;
        end
`endif
        if (start_stop) begin
          if (m_st == M_IDLE || m_st == M_PAUSE) begin
            m_mode = mode;
            nst = (mode && m_tot == 0) ? M_DONE : M_RUN;
          end else if (m_st == M_RUN) begin
            nst = M_PAUSE;
          end
        end
        if (tick && m_st == M_RUN) begin
          if (!m_mode) begin
            if (m_tot == LIMIT_TOT) nst = M_DONE;
            else m_tot = m_tot + 1;
          end else begin
            if (m_tot > 0) m_tot = m_tot - 1;
            if (m_tot == 0) nst = M_DONE;
          end
        end
        if (nst == M_DONE) m_hold = 0;
      end
      m_st = nst;
    end
  end

  task automatic cmp(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle after reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model disp_min", int'(disp_min), int'(int_to_bcd((m_hold ? m_held : m_tot) / 60)));
      cmp("model disp_sec", int'(disp_sec), int'(int_to_bcd((m_hold ? m_held : m_tot) % 60)));
      cmp("model running", int'(running), int'(m_st == M_RUN));
      cmp("model done", int'(done), int'(m_st == M_DONE));
      cmp("model load_err", int'(load_err), int'(m_err));
    end
  end

  task automatic applyStimulus(input bit ss, input bit clr, input bit ld, input bit tk, input bit lp);
    start_stop = ss; clear = clr; load = ld; tick = tk; lap = lp;
    @(negedge clk);
    start_stop = 0; clear = 0; load = 0; tick = 0; lap = 0;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic loadPreset(input logic [7:0] pm, input logic [7:0] ps);
    preset_min = pm; preset_sec = ps;
    applyStimulus(0, 0, 1, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] em, input logic [7:0] es,
                             input bit er, input bit ed, input bit ee);
    cmp({name, " min"}, int'(disp_min), int'(em));
    cmp({name, " sec"}, int'(disp_sec), int'(es));
    cmp({name, " running"}, int'(running), int'(er));
    cmp({name, " done"}, int'(done), int'(ed));
    cmp({name, " load_err"}, int'(load_err), int'(ee));
  endtask

  initial begin
    reset = 1; tick = 0; start_stop = 0; clear = 0; load = 0; mode = 0; lap = 0;
    preset_min = 0; preset_sec = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    checkOutput("reset", 8'h00, 8'h00, 0, 0, 0);

    mode = 0;
    applyStimulus(1, 0, 0, 0, 0);
    tickN(61);
    checkOutput("up 61 ticks", 8'h01, 8'h01, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tickN(5);
    checkOutput("paused", 8'h01, 8'h01, 0, 0, 0);

    loadPreset(8'h00, 8'h03);
    mode = 1;
    applyStimulus(1, 0, 0, 0, 0);
    tickN(1); checkOutput("down 1", 8'h00, 8'h02, 1, 0, 0);
    tickN(1); checkOutput("down 2", 8'h00, 8'h01, 1, 0, 0);
    tickN(1); checkOutput("down done", 8'h00, 8'h00, 0, 1, 0);
    tickN(2); checkOutput("down hold", 8'h00, 8'h00, 0, 1, 0);

    loadPreset(8'h99, 8'h58);
    mode = 0;
    applyStimulus(1, 0, 0, 0, 0);
    tickN(1); checkOutput("up 99:59", 8'h99, 8'h59, 1, 0, 0);
    tickN(1); checkOutput("up limit", 8'h99, 8'h59, 0, 1, 0);
    tickN(2); checkOutput("limit hold", 8'h99, 8'h59, 0, 1, 0);

    loadPreset(8'h00, 8'h6A);
    checkOutput("bad load", 8'h99, 8'h59, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("err pulse end", 8'h99, 8'h59, 0, 1, 0);
    loadPreset(8'h00, 8'h05);
    applyStimulus(1, 0, 0, 0, 0);
    loadPreset(8'h12, 8'h34);
    checkOutput("load in run", 8'h00, 8'h05, 1, 0, 0);

    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("clear", 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("start+tick", 8'h00, 8'h00, 1, 0, 0);
    tickN(3);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("clear+stop", 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tickN(4);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checkOutput("reset mid run", 8'h00, 8'h00, 0, 0, 0);

    mode = 1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("down empty start", 8'h00, 8'h00, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);

    mode = 0;
    applyStimulus(1, 0, 0, 0, 0);
    tickN(10);
    checkOutput("pre lap", 8'h00, 8'h10, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    tickN(5);
`ifdef STOPWATCH_LAP_HOLD_EN
    checkOutput("lap frozen", 8'h00, 8'h10, 1, 0, 0);
`else
    checkOutput("lap ignored", 8'h00, 8'h15, 1, 0, 0);
`endif
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap release", 8'h00, 8'h15, 1, 0, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
